// File: rtl/radio_pkg.sv
// radio_pkg: shared types and constants for the radio serial link engine.
//   tx_state_e  - transmit FSM states (idle / shifting a word out)
//   rx_state_e  - receive FSM states (idle / sampling a word in)
//   IDLE_LINE   - level driven on Tx whenever no word is being sent
package radio_pkg;

   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_e;

   typedef enum logic {
      RX_IDLE   = 1'b0,
      RX_SAMPLE = 1'b1
   } rx_state_e;

   localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/radio_bit_timer.sv
// radio_bit_timer: bit-period divider for one serial path.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the last cycle of
// each bit period, so the edge that ends a tick cycle is a bit boundary.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  hold the divider at 0 (path idle)
//   tick   out last cycle of the current bit period
module radio_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // With CLKS_PER_BIT=1 the counter is pinned at 0 and every cycle ticks.
   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/radio.sv
// radio: minimal full-duplex raw serial link engine (no start/stop bits).
// TX: a send pulse in idle latches tx_data and shifts it out on Tx LSB first,
//     one bit per CLKS_PER_BIT cycles; busy covers the whole word.
// RX: while receive is high, Rx is sampled in the last cycle of each bit
//     period, LSB first; each completed word lands on rx_data with a
//     one-cycle rx_valid pulse. Dropping receive discards a partial word.
// enable low forces both paths idle at the next edge; rx_data is kept.
//   clk, rst_n        clock / asynchronous active-low reset
//   enable            block enable
//   send, tx_data     transmit request and word
//   busy, Tx          transmit in progress, serial output (registered)
//   receive, Rx       receive window (level) and serial input
//   rx_data, rx_valid last completed word and its update strobe
// Rx is used without a synchronizer; add one outside if it is asynchronous.
module radio
   import radio_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  send,
   output logic                  busy,
   input  logic                  receive,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  Tx,
   input  logic                  Rx
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   // ---------------- transmit path ----------------
   tx_state_e             tx_state_q, tx_state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [BW-1:0]         tx_bit_q,   tx_bit_d;
   logic                  tx_line_q,  tx_line_d;
   logic                  tx_clear;
   logic                  tx_tick;

   // The divider only runs while a word is on the line.
   assign tx_clear = (tx_state_q != TX_SHIFT) || !enable;

   radio_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tx_clear),
      .tick  (tx_tick)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_line_d  = tx_line_q;
      if (!enable) begin
         tx_state_d = TX_IDLE;
         tx_bit_d   = '0;
         tx_line_d  = IDLE_LINE;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_bit_d  = '0;
               tx_line_d = IDLE_LINE;
               if (send) begin
                  tx_state_d = TX_SHIFT;
                  tx_shift_d = tx_data;
                  tx_line_d  = tx_data[0];
               end
            end
            TX_SHIFT: begin
               // send is ignored here; a request is only seen in TX_IDLE.
               if (tx_tick) begin
                  if (tx_bit_q == LAST_BIT) begin
                     tx_state_d = TX_IDLE;
                     tx_bit_d   = '0;
                     tx_line_d  = IDLE_LINE;
                  end else begin
                     tx_shift_d = tx_shift_q >> 1;
                     tx_line_d  = tx_shift_q[1];
                     tx_bit_d   = tx_bit_q + 1'b1;
                  end
               end
            end
            default: begin
               tx_state_d = TX_IDLE;
               tx_line_d  = IDLE_LINE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_line_q  <= IDLE_LINE;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign busy = (tx_state_q == TX_SHIFT);
   assign Tx   = tx_line_q;

   // ---------------- receive path ----------------
   rx_state_e             rx_state_q, rx_state_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
   logic [BW-1:0]         rx_bit_q,   rx_bit_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_run;
   logic                  rx_tick;

   // The entry edge is already the first cycle of bit 0, so the divider is
   // released as soon as the window opens rather than after entering SAMPLE.
   assign rx_run = enable && receive;

   radio_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!rx_run),
      .tick  (rx_tick)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_bit_d   = rx_bit_q;
      rx_valid_d = 1'b0;
      if (!rx_run) begin
         // Window closed or block disabled: drop any partial word.
         rx_state_d = RX_IDLE;
         rx_bit_d   = '0;
      end else begin
         rx_state_d = RX_SAMPLE;
         if (rx_tick) begin
            rx_shift_d = {Rx, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_q == LAST_BIT) begin
               rx_data_d  = rx_shift_d;
               rx_valid_d = 1'b1;
               rx_bit_d   = '0;
            end else begin
               rx_bit_d = rx_bit_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_bit_q   <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_bit_q   <= rx_bit_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_radio.sv
// tb_radio: directed, table-driven bench for radio (DATA_WIDTH=8,
// CLKS_PER_BIT=1). Inputs change 1 time unit after a rising edge and the
// outputs produced by that edge are compared at the same moment.
module tb_radio;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       send;
   logic       busy;
   logic       receive;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx;
   logic       rx;

   radio #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .send     (send),
      .busy     (busy),
      .receive  (receive),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .Tx       (tx),
      .Rx       (rx)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic       en;
      logic       snd;
      logic [7:0] txd;
      logic       rcv;
      logic       rxb;
      logic       e_busy;
      logic       e_tx;
      logic       e_rv;
      logic [7:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   int n_vec = 0;
   int n_err = 0;

   function automatic void add(input logic en, input logic snd, input logic [7:0] txd,
                               input logic rcv, input logic rxb, input logic e_busy,
                               input logic e_tx, input logic e_rv, input logic [7:0] e_rd);
      vec_t v;
      v.en = en; v.snd = snd; v.txd = txd; v.rcv = rcv; v.rxb = rxb;
      v.e_busy = e_busy; v.e_tx = e_tx; v.e_rv = e_rv; v.e_rd = e_rd;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_busy, input logic e_tx,
                            input logic e_rv, input logic [7:0] e_rd);
      check({tag, " busy"},     {7'd0, busy},     {7'd0, e_busy});
      check({tag, " Tx"},       {7'd0, tx},       {7'd0, e_tx});
      check({tag, " rx_valid"}, {7'd0, rx_valid}, {7'd0, e_rv});
      check({tag, " rx_data"},  rx_data,          e_rd);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] p;
      logic [7:0] r1;
      logic [7:0] r2;
      logic [7:0] rd;

      rst_n   = 1'b1;
      enable  = 1'b0;
      send    = 1'b0;
      receive = 1'b0;
      tx_data = 8'h00;
      rx      = 1'b0;

      // Reset values appear without any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check_all("reset_initial", 1'b0, 1'b1, 1'b0, 8'h00);
      step();
      step();
      rst_n = 1'b1;

      // Phase A: transmit 0xAA, one-cycle send pulse.
      p = 8'hAA;
      add(1, 1, p, 0, 0, 1, p[0], 0, 8'h00);
      for (int i = 1; i < 8; i++) add(1, 0, p, 0, 0, 1, p[i], 0, 8'h00);
      add(1, 0, p, 0, 0, 0, 1, 0, 8'h00);

      // Phase B: 0x0F transfer, second send (0xFF) 3 cycles in is ignored.
      p = 8'h0F;
      add(1, 1, p, 0, 0, 1, p[0], 0, 8'h00);
      add(1, 0, p, 0, 0, 1, p[1], 0, 8'h00);
      add(1, 0, p, 0, 0, 1, p[2], 0, 8'h00);
      add(1, 1, 8'hFF, 0, 0, 1, p[3], 0, 8'h00);
      for (int i = 4; i < 8; i++) add(1, 0, 8'hFF, 0, 0, 1, p[i], 0, 8'h00);
      add(1, 0, 8'hFF, 0, 0, 0, 1, 0, 8'h00);
      add(1, 0, 8'hFF, 0, 0, 0, 1, 0, 8'h00);

      // Phase C: receive Rx = 1,0,1,1,0,0,1,0 -> 0x4D.
      p = 8'h4D;
      for (int i = 0; i < 8; i++)
         add(1, 0, 8'h00, 1, p[i], 0, 1, (i == 7), (i == 7) ? 8'h4D : 8'h00);
      add(1, 0, 8'h00, 0, 0, 0, 1, 0, 8'h4D);

      // Phase D: receive dropped after 5 bits, word discarded.
      for (int i = 0; i < 5; i++) add(1, 0, 8'h00, 1, 1, 0, 1, 0, 8'h4D);
      add(1, 0, 8'h00, 0, 1, 0, 1, 0, 8'h4D);
      add(1, 0, 8'h00, 0, 1, 0, 1, 0, 8'h4D);

      // Phase E: back-to-back receive of 0x01 then 0x80 while sending 0x55.
      p  = 8'h55;
      r1 = 8'h01;
      r2 = 8'h80;
      for (int i = 0; i < 16; i++) begin
         if (i < 7)       rd = 8'h4D;
         else if (i < 15) rd = 8'h01;
         else             rd = 8'h80;
         add(1, (i == 0), p, 1, (i < 8) ? r1[i] : r2[i-8],
             (i < 8), (i < 8) ? p[i] : 1'b1, (i == 7) || (i == 15), rd);
      end
      add(1, 0, p, 0, 0, 0, 1, 0, 8'h80);

      // Phase F: send held high restarts on the first idle edge.
      p = 8'h81;
      for (int i = 0; i < 8; i++) add(1, 1, p, 0, 0, 1, p[i], 0, 8'h80);
      add(1, 1, p, 0, 0, 0, 1, 0, 8'h80);
      add(1, 1, p, 0, 0, 1, p[0], 0, 8'h80);
      for (int i = 1; i < 8; i++) add(1, 0, p, 0, 0, 1, p[i], 0, 8'h80);
      add(1, 0, p, 0, 0, 0, 1, 0, 8'h80);

      foreach (vecs[k]) begin
         enable  = vecs[k].en;
         send    = vecs[k].snd;
         tx_data = vecs[k].txd;
         receive = vecs[k].rcv;
         rx      = vecs[k].rxb;
         step();
         check_all($sformatf("vec%0d", k), vecs[k].e_busy, vecs[k].e_tx,
                   vecs[k].e_rv, vecs[k].e_rd);
      end

      // enable dropped while bit 3 of 0xF0 is on the line.
      p       = 8'hF0;
      enable  = 1'b1;
      send    = 1'b1;
      tx_data = p;
      step();
      check_all("en_abort_start", 1'b1, p[0], 1'b0, 8'h80);
      send = 1'b0;
      for (int i = 1; i < 4; i++) step();
      check_all("en_abort_bit3", 1'b1, p[3], 1'b0, 8'h80);
      enable  = 1'b0;
      receive = 1'b1;
      rx      = 1'b1;
      step();
      check_all("en_abort_edge", 1'b0, 1'b1, 1'b0, 8'h80);
      // While disabled, send and a full receive window are both ignored.
      send = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("en_low%0d", i), 1'b0, 1'b1, 1'b0, 8'h80);
      end
      enable  = 1'b1;
      receive = 1'b0;
      step();
      check_all("en_resume_start", 1'b1, p[0], 1'b0, 8'h80);
      send = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step();
         check_all($sformatf("en_resume_bit%0d", i), 1'b1, p[i], 1'b0, 8'h80);
      end
      step();
      check_all("en_resume_done", 1'b0, 1'b1, 1'b0, 8'h80);

      // Asynchronous reset in the middle of a transmit and a receive.
      send    = 1'b1;
      tx_data = 8'h00;
      receive = 1'b1;
      rx      = 1'b1;
      step();
      send = 1'b0;
      step();
      step();
      check_all("pre_reset", 1'b1, 1'b0, 1'b0, 8'h80);
      #2 rst_n = 1'b0;
      #1;
      check_all("reset_async", 1'b0, 1'b1, 1'b0, 8'h00);
      enable  = 1'b0;
      receive = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check_all("after_reset", 1'b0, 1'b1, 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/radio.md
Name: radio

Overview:
- Minimal full-duplex serial link engine for the wireless sensor node.
- Transmit path: latches a byte on a `send` pulse and shifts it out on `Tx`, LSB first, one bit per bit period, with `busy` asserted for the whole transfer.
- Receive path: while `receive` is held high, samples `Rx` once per bit period, LSB first, and publishes each completed byte on `rx_data`.
- Raw framing, no start/stop bits. Sits between the node controller and the radio front-end pins.

Parameters:
- DATA_WIDTH, 8, bits per word, both directions.
- CLKS_PER_BIT, 1, clock cycles per serial bit; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low forces both paths idle.
- send  in  1  transmit request, sampled each clk.
- busy  out  1  high while a transmit is in progress.
- receive  in  1  receive window; level-sensitive.
- tx_data  in  DATA_WIDTH  word to transmit, latched on accepted send.
- rx_data  out  DATA_WIDTH  last completed received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- Tx  out  1  serial transmit line.
- Rx  in  1  serial receive line.

Behaviour:
- Reset (rst_n low, async) drives: busy=0, Tx=1, rx_data=0, rx_valid=0, both FSMs IDLE, all counters and shift registers 0.
- Bit timer: each path has its own divider counting 0..CLKS_PER_BIT-1. A bit boundary occurs when the divider wraps. Dividers are cleared whenever the path is IDLE.
- TX FSM, states IDLE and SHIFT:
  - IDLE: Tx=1, busy=0.
  - Accept condition: enable=1 and send=1 at a rising edge while in IDLE.
  - On accept: at that edge, tx_data is latched into the shift register, busy=1, and Tx=bit0 (registered output, visible after that edge).
  - Each bit is held for CLKS_PER_BIT cycles, then the next bit is presented, LSB first.
  - After bit DATA_WIDTH-1 has been held its full period, return to IDLE: busy=0 and Tx=1 at the same edge.
  - busy is therefore high for exactly DATA_WIDTH*CLKS_PER_BIT cycles.
  - send while busy is ignored, with no queueing. send held high after completion starts a new transfer on the first IDLE edge.
  - tx_data changes during SHIFT have no effect.
- RX FSM, states IDLE and SAMPLE:
  - Enter SAMPLE at the first edge where enable=1 and receive=1.
  - Rx is sampled at the last cycle of each bit period; with CLKS_PER_BIT=1, every edge while in SAMPLE, including the entry edge.
  - Each sample is shifted in at the MSB end with a right shift, so the first bit ends up in bit 0.
  - After DATA_WIDTH samples: rx_data is loaded from the shift register, rx_valid pulses for 1 cycle, the bit count restarts at 0, and the FSM stays in SAMPLE while receive remains high (back-to-back words).
  - receive falling mid-word: the partial word is discarded, rx_data is unchanged, no rx_valid, return to IDLE.
  - rx_data holds its value until the next completed word or reset.
- enable low:
  - Both FSMs go to IDLE at the next edge, aborting any transfer.
  - Outputs: busy=0, Tx=1; rx_data is held.
- Concurrency: the TX and RX paths are fully independent; send and receive may be active simultaneously.
- Rx is used directly with no synchronizer. The integrator adds one if Rx is asynchronous.

Decomposition:
- Package radio_pkg: state enum for the TX and RX FSMs (IDLE/SHIFT, IDLE/SAMPLE) and an idle-line constant (1'b1).
- Natural sub-module: radio_bit_timer, a parameterized CLKS_PER_BIT divider with clear input and tick output, instantiated once per path.

Test Plan:
- Reset: assert rst_n=0 mid-operation. Required: busy=0, Tx=1, rx_data=0 immediately, without waiting for a clock.
- TX, CLKS_PER_BIT=1: enable=1, tx_data=0xAA, send pulsed 1 cycle. Required: Tx sequence 0,1,0,1,0,1,0,1 on consecutive cycles, busy high exactly 8 cycles, then Tx=1 and busy=0.
- TX ignore: a second send pulse with tx_data=0xFF issued 3 cycles into a 0x0F transfer. Required: Tx sequence 1,1,1,1,0,0,0,0 and busy high only 8 cycles.
- RX: receive=1 for 8 cycles with Rx=1,0,1,1,0,0,1,0 on successive edges. Required: rx_data=0x4D and one rx_valid pulse.
- RX abort: receive dropped after 5 bits. Required: rx_data unchanged (0x4D) and no rx_valid.
- enable=0 during TX at bit 3. Required: busy=0 and Tx=1 on the next edge; subsequent send is ignored until enable=1.
